alu_acc: RTL and testbench

- Parametrised, registered successor to the 4-bit enable/select add-sub unit driving the board LEDs.
- Generalises data width, extends the mode select to four operations and adds an internal accumulator with an operation counter.
- Adds carry/borrow, zero and overflow flags (plus a sticky overflow) and a one-cycle registered result with a valid strobe.
- Sits between switch/key input logic and the LED or 7-segment display driver.

---
 rtl/alu_acc_if.sv | 31 +++
 rtl/alu_acc.sv | 131 +++++++++++++
 tb/tb_alu_acc.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_acc_if.sv
// alu_acc_if: operand/result bundle between the switch/key input logic and
// the alu_acc datapath. The master drives operands and control, the slave
// (alu_acc) returns the registered result, flags and accumulate count.
interface alu_acc_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             load;
    logic             in_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [WIDTH-1:0] output_c;
    logic             out_valid;
    logic             carry;
    logic             zero;
    logic             overflow;
    logic             ovf_sticky;
    logic [CNT_W-1:0] acc_cnt;

    modport master (
        output en, load, in_valid, op, input_a, input_b,
        input  output_c, out_valid, carry, zero, overflow, ovf_sticky, acc_cnt
    );

    modport slave (
        input  en, load, in_valid, op, input_a, input_b,
        output output_c, out_valid, carry, zero, overflow, ovf_sticky, acc_cnt
    );
endinterface

// File: rtl/alu_acc.sv
// alu_acc: registered add/sub unit with an internal accumulator.
// op: 00 a+b, 01 a-b, 10 acc+a, 11 acc-a. Every output is a register; the
// result and flags appear one clock after the accepting edge.
// Optional build macro ALU_SAT_EN: unsigned saturation of the result (add
// with carry clamps to all ones, sub with borrow clamps to zero). The flags
// still report the unclamped condition; zero follows the clamped value.
module alu_acc #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_acc_if.slave  bus
);
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] acc_cnt_r;
    logic [WIDTH-1:0] output_c_r;
    logic             out_valid_r;
    logic             carry_r;
    logic             zero_r;
    logic             overflow_r;
    logic             ovf_sticky_r;

    logic [WIDTH-1:0] first_s;
    logic [WIDTH-1:0] second_s;
    logic             is_sub_s;
    logic [WIDTH:0]   raw_s;
    logic [WIDTH-1:0] wrap_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             overflow_s;

    // Operand selection and WIDTH+1-bit arithmetic with carry/borrow and signed overflow.
    always_comb begin
        first_s    = {WIDTH{1'b0}};
        second_s   = {WIDTH{1'b0}};
        is_sub_s   = bus.op[0];
        raw_s      = {(WIDTH+1){1'b0}};
        overflow_s = 1'b0;
        if (bus.op[1]) begin
            first_s  = acc_r;
            second_s = bus.input_a;
        end else begin
            first_s  = bus.input_a;
            second_s = bus.input_b;
        end
        if (is_sub_s) begin
            // Top bit of the extended difference is set exactly when first < second.
            raw_s      = {1'b0, first_s} - {1'b0, second_s};
            overflow_s = (first_s[WIDTH-1] != second_s[WIDTH-1]) &&
                         (raw_s[WIDTH-1] != first_s[WIDTH-1]);
        end else begin
            raw_s      = {1'b0, first_s} + {1'b0, second_s};
            overflow_s = (first_s[WIDTH-1] == second_s[WIDTH-1]) &&
                         (raw_s[WIDTH-1] != first_s[WIDTH-1]);
        end
        carry_s = raw_s[WIDTH];
        wrap_s  = raw_s[WIDTH-1:0];
    end

    // Final result: clamped on carry/borrow when saturation is built in, otherwise wrapped.
    always_comb begin
        result_s = wrap_s;
`ifdef ALU_SAT_EN
        if (carry_s) begin
            if (is_sub_s) begin
                result_s = {WIDTH{1'b0}};
            end else begin
                result_s = {WIDTH{1'b1}};
            end
        end else begin
            result_s = wrap_s;
        end
`endif
    end

    // State and output registers; priority rst > disabled > load > in_valid > idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r        <= {WIDTH{1'b0}};
            acc_cnt_r    <= {CNT_W{1'b0}};
            output_c_r   <= {WIDTH{1'b1}};
            out_valid_r  <= 1'b0;
            carry_r      <= 1'b0;
            zero_r       <= 1'b0;
            overflow_r   <= 1'b0;
            ovf_sticky_r <= 1'b0;
        end else if (!bus.en) begin
            // Display blank; accumulator state is preserved across the disable.
            output_c_r  <= {WIDTH{1'b1}};
            out_valid_r <= 1'b0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (bus.load) begin
            // Load wins over a simultaneous in_valid, which is dropped.
            acc_r        <= bus.input_a;
            acc_cnt_r    <= {CNT_W{1'b0}};
            output_c_r   <= bus.input_a;
            out_valid_r  <= 1'b1;
            carry_r      <= 1'b0;
            zero_r       <= (bus.input_a == {WIDTH{1'b0}});
            overflow_r   <= 1'b0;
            ovf_sticky_r <= 1'b0;
        end else if (bus.in_valid) begin
            output_c_r   <= result_s;
            out_valid_r  <= 1'b1;
            carry_r      <= carry_s;
            zero_r       <= (result_s == {WIDTH{1'b0}});
            overflow_r   <= overflow_s;
            ovf_sticky_r <= ovf_sticky_r | overflow_s;
            if (bus.op[1]) begin
                acc_r     <= result_s;
                acc_cnt_r <= acc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                acc_r     <= acc_r;
                acc_cnt_r <= acc_cnt_r;
            end
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.output_c   = output_c_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.carry      = carry_r;
    assign bus.zero       = zero_r;
    assign bus.overflow   = overflow_r;
    assign bus.ovf_sticky = ovf_sticky_r;
    assign bus.acc_cnt    = acc_cnt_r;
endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc: directed-vector bench for alu_acc (WIDTH=4, CNT_W=8).
// Inputs change 1 ns after the rising edge; outputs are compared there too.
module tb_alu_acc;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_acc_if #(.WIDTH(4), .CNT_W(8)) bus ();

    alu_acc #(.WIDTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic e, input logic l, input logic iv,
                         input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
        bus.en       = e;
        bus.load     = l;
        bus.in_valid = iv;
        bus.op       = o;
        bus.input_a  = a;
        bus.input_b  = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
        #3;
        checks++;
        if (bus.output_c !== 4'hF || bus.acc_cnt !== 8'd0 || bus.out_valid !== 1'b0 ||
            bus.carry !== 1'b0 || bus.zero !== 1'b0 || bus.overflow !== 1'b0 || bus.ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: c=%h cnt=%0d v=%b cy=%b z=%b ov=%b st=%b, need c=f cnt=0 flags 0",
                     bus.output_c, bus.acc_cnt, bus.out_valid, bus.carry, bus.zero, bus.overflow, bus.ovf_sticky);
        end
        tick();
        rst = 1'b0;
        // Build up state (result, overflow, sticky, count) then reset mid-stream.
        drive(1'b1, 1'b0, 1'b1, 2'b10, 4'h7, 4'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 2'b00, 4'h7, 4'h5);
        tick();
        drive(1'b1, 1'b0, 1'b1, 2'b00, 4'h1, 4'h1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.output_c !== 4'hF || bus.acc_cnt !== 8'd0 || bus.out_valid !== 1'b0 ||
            bus.carry !== 1'b0 || bus.zero !== 1'b0 || bus.overflow !== 1'b0 || bus.ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: c=%h cnt=%0d v=%b cy=%b z=%b ov=%b st=%b, need c=f cnt=0 flags 0",
                     bus.output_c, bus.acc_cnt, bus.out_valid, bus.carry, bus.zero, bus.overflow, bus.ovf_sticky);
        end
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.output_c !== 4'hF) begin
            errors++;
            $display("FAIL reset_release: v=%b c=%h, need v=0 c=f", bus.out_valid, bus.output_c);
        end
    endtask

    task automatic test_add_sub();
        drive(1'b1, 1'b0, 1'b1, 2'b00, 4'h7, 4'h5);
        tick();
        checks++;
        if (bus.output_c !== 4'hC || bus.carry !== 1'b0 || bus.overflow !== 1'b1 ||
            bus.out_valid !== 1'b1 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL add_7_5: c=%h cy=%b ov=%b v=%b z=%b, need c=c cy=0 ov=1 v=1 z=0",
                     bus.output_c, bus.carry, bus.overflow, bus.out_valid, bus.zero);
        end
        drive(1'b1, 1'b0, 1'b1, 2'b01, 4'h3, 4'h5);
        tick();
        checks++;
        if (bus.output_c !== 4'hE || bus.carry !== 1'b1 || bus.overflow !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sub_3_5: c=%h cy=%b ov=%b v=%b, need c=e cy=1 ov=0 v=1",
                     bus.output_c, bus.carry, bus.overflow, bus.out_valid);
        end
        drive(1'b1, 1'b0, 1'b1, 2'b01, 4'h5, 4'h5);
        tick();
        checks++;
        if (bus.output_c !== 4'h0 || bus.zero !== 1'b1 || bus.carry !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL sub_zero: c=%h z=%b cy=%b ov=%b, need c=0 z=1 cy=0 ov=0",
                     bus.output_c, bus.zero, bus.carry, bus.overflow);
        end
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'h9, 4'h9);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.output_c !== 4'h0 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: v=%b c=%h z=%b, need v=0 c=0 z=1", bus.out_valid, bus.output_c, bus.zero);
        end
    endtask

    task automatic test_enable();
        drive(1'b1, 1'b1, 1'b0, 2'b00, 4'h6, 4'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 2'b00, 4'h1, 4'h1);
        tick();
        checks++;
        if (bus.output_c !== 4'hF || bus.out_valid !== 1'b0 || bus.carry !== 1'b0 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL disable_blank: c=%h v=%b cy=%b z=%b, need c=f v=0 cy=0 z=0",
                     bus.output_c, bus.out_valid, bus.carry, bus.zero);
        end
        // Load and accumulate requests while disabled must be ignored.
        drive(1'b0, 1'b1, 1'b1, 2'b10, 4'h3, 4'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
        tick();
        checks++;
        if (bus.output_c !== 4'hF || bus.out_valid !== 1'b0 || bus.acc_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reenable_idle: c=%h v=%b cnt=%0d, need c=f v=0 cnt=0",
                     bus.output_c, bus.out_valid, bus.acc_cnt);
        end
        drive(1'b1, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
        tick();
        checks++;
        if (bus.output_c !== 4'h6 || bus.acc_cnt !== 8'd1) begin
            errors++;
            $display("FAIL acc_kept: c=%h cnt=%0d, need c=6 cnt=1", bus.output_c, bus.acc_cnt);
        end
    endtask

    task automatic test_accumulate();
        drive(1'b1, 1'b1, 1'b0, 2'b00, 4'h2, 4'h0);
        tick();
        checks++;
        if (bus.output_c !== 4'h2 || bus.acc_cnt !== 8'd0 || bus.out_valid !== 1'b1 || bus.ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL load_2: c=%h cnt=%0d v=%b st=%b, need c=2 cnt=0 v=1 st=0",
                     bus.output_c, bus.acc_cnt, bus.out_valid, bus.ovf_sticky);
        end
        drive(1'b1, 1'b0, 1'b1, 2'b10, 4'h3, 4'h0);
        tick();
        checks++;
        if (bus.output_c !== 4'h5 || bus.ovf_sticky !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL acc_step1: c=%h st=%b v=%b, need c=5 st=0 v=1", bus.output_c, bus.ovf_sticky, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.output_c !== 4'h8 || bus.overflow !== 1'b1 || bus.ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL acc_step2: c=%h ov=%b st=%b, need c=8 ov=1 st=1", bus.output_c, bus.overflow, bus.ovf_sticky);
        end
        tick();
        checks++;
        if (bus.output_c !== 4'hB || bus.overflow !== 1'b0 || bus.ovf_sticky !== 1'b1 || bus.acc_cnt !== 8'd3) begin
            errors++;
            $display("FAIL acc_step3: c=%h ov=%b st=%b cnt=%0d, need c=b ov=0 st=1 cnt=3",
                     bus.output_c, bus.overflow, bus.ovf_sticky, bus.acc_cnt);
        end
        drive(1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
        tick();
        checks++;
        if (bus.ovf_sticky !== 1'b0 || bus.zero !== 1'b1 || bus.acc_cnt !== 8'd0 || bus.output_c !== 4'h0) begin
            errors++;
            $display("FAIL load_clear: st=%b z=%b cnt=%0d c=%h, need st=0 z=1 cnt=0 c=0",
                     bus.ovf_sticky, bus.zero, bus.acc_cnt, bus.output_c);
        end
        // acc - a from zero: borrow; clamps to 0 when saturation is built in.
        drive(1'b1, 1'b0, 1'b1, 2'b11, 4'h1, 4'h0);
        tick();
        checks++;
`ifdef ALU_SAT_EN
        if (bus.output_c !== 4'h0 || bus.carry !== 1'b1 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL acc_sub_borrow: c=%h cy=%b z=%b ov=%b, need c=0 cy=1 z=1 ov=0",
                     bus.output_c, bus.carry, bus.zero, bus.overflow);
        end
`else
        if (bus.output_c !== 4'hF || bus.carry !== 1'b1 || bus.zero !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL acc_sub_borrow: c=%h cy=%b z=%b ov=%b, need c=f cy=1 z=0 ov=0",
                     bus.output_c, bus.carry, bus.zero, bus.overflow);
        end
`endif
    endtask

    task automatic test_load_priority();
        drive(1'b1, 1'b1, 1'b1, 2'b10, 4'h9, 4'h0);
        tick();
        checks++;
        if (bus.output_c !== 4'h9 || bus.acc_cnt !== 8'd0 || bus.out_valid !== 1'b1 || bus.carry !== 1'b0) begin
            errors++;
            $display("FAIL load_vs_op: c=%h cnt=%0d v=%b cy=%b, need c=9 cnt=0 v=1 cy=0",
                     bus.output_c, bus.acc_cnt, bus.out_valid, bus.carry);
        end
        drive(1'b1, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
        tick();
        checks++;
        if (bus.output_c !== 4'h9 || bus.acc_cnt !== 8'd1) begin
            errors++;
            $display("FAIL acc_after_load: c=%h cnt=%0d, need c=9 cnt=1", bus.output_c, bus.acc_cnt);
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b0, 1'b1, 2'b00, 4'hC, 4'h6);
        tick();
        checks++;
`ifdef ALU_SAT_EN
        if (bus.output_c !== 4'hF || bus.carry !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_add: c=%h cy=%b ov=%b, need c=f cy=1 ov=0", bus.output_c, bus.carry, bus.overflow);
        end
`else
        if (bus.output_c !== 4'h2 || bus.carry !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_add: c=%h cy=%b ov=%b, need c=2 cy=1 ov=0", bus.output_c, bus.carry, bus.overflow);
        end
`endif
        drive(1'b1, 1'b0, 1'b1, 2'b01, 4'h2, 4'h6);
        tick();
        checks++;
`ifdef ALU_SAT_EN
        if (bus.output_c !== 4'h0 || bus.zero !== 1'b1 || bus.carry !== 1'b1) begin
            errors++;
            $display("FAIL sat_sub: c=%h z=%b cy=%b, need c=0 z=1 cy=1", bus.output_c, bus.zero, bus.carry);
        end
`else
        if (bus.output_c !== 4'hC || bus.zero !== 1'b0 || bus.carry !== 1'b1) begin
            errors++;
            $display("FAIL wrap_sub: c=%h z=%b cy=%b, need c=c z=0 cy=1", bus.output_c, bus.zero, bus.carry);
        end
`endif
    endtask

    task automatic test_cnt_wrap();
        drive(1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        checks++;
        if (bus.acc_cnt !== 8'd255) begin
            errors++;
            $display("FAIL cnt_full: cnt=%0d, need 255", bus.acc_cnt);
        end
        tick();
        checks++;
        if (bus.acc_cnt !== 8'd0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL cnt_wrap: cnt=%0d v=%b, need cnt=0 v=1", bus.acc_cnt, bus.out_valid);
        end
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
        test_reset();
        test_add_sub();
        test_enable();
        test_accumulate();
        test_load_priority();
        test_saturation();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
